retire_unit: RTL and testbench

- Consumer end of the 5-bit in-order tag queue: reads the head tag and waits for that tag's completion.
- Retires tags strictly in program order, one per cycle, and pops the queue on each retire.
- On a faulting head, squashes everything: clears the queue, clears all status, holds off for a fixed drain window.
- Sits between the tag queue and the writeback/exception logic of the pipeline.

---
 rtl/mips_pkg.sv | 18 +
 rtl/tag_status_table.sv | 69 ++++++
 rtl/retire_unit.sv | 139 +++++++++++++
 tb/tb_retire_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared tag-width, hold-timer and retire-FSM definitions.  Rev 1.0
// ============================================================================
package mips_pkg;

    localparam int MIPS_TAG_W        = 5;
    localparam int MIPS_FLUSH_CYCLES = 4;
    localparam int HOLD_CNT_W        = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } retire_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/tag_status_table.sv
`default_nettype none
// ============================================================================
// tag_status_table : per-tag done/exc bits with head read port.  Rev 1.0
// Optional: RETIRE_CMPL_BYPASS_EN forwards a same-cycle completion to the head.
// ============================================================================
module tag_status_table
    import mips_pkg::*;
#(
    parameter int TAG_W = MIPS_TAG_W
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             set_en_i,
    input  logic [TAG_W-1:0] set_tag_i,
    input  logic             set_exc_i,
    input  logic             clr_en_i,
    input  logic [TAG_W-1:0] clr_tag_i,
    input  logic             clr_all_i,
    input  logic [TAG_W-1:0] head_tag_i,
    output logic             head_done_o,
    output logic             head_exc_o
);

    localparam int c_DEPTH = 2 ** TAG_W;

    logic [c_DEPTH-1:0] done_q, done_d;
    logic [c_DEPTH-1:0] exc_q,  exc_d;

    // Clear-one is applied after set so a retiring tag never keeps a stale bit.
    always_comb begin
        done_d = done_q;
        exc_d  = exc_q;
        if (clr_all_i) begin
            done_d = '0;
            exc_d  = '0;
        end else begin
            if (set_en_i) begin
                done_d[set_tag_i] = 1'b1;
                exc_d[set_tag_i]  = set_exc_i;
            end
            if (clr_en_i) begin
                done_d[clr_tag_i] = 1'b0;
                exc_d[clr_tag_i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            done_q <= '0;
            exc_q  <= '0;
        end else begin
            done_q <= done_d;
            exc_q  <= exc_d;
        end
    end

`ifdef RETIRE_CMPL_BYPASS_EN
    logic w_hit;
    assign w_hit       = set_en_i && (set_tag_i == head_tag_i);
    assign head_done_o = done_q[head_tag_i] | w_hit;
    assign head_exc_o  = w_hit ? set_exc_i : exc_q[head_tag_i];
`else
    assign head_done_o = done_q[head_tag_i];
    assign head_exc_o  = exc_q[head_tag_i];
`endif

endmodule : tag_status_table
`default_nettype wire

// File: rtl/retire_unit.sv
`default_nettype none
// ============================================================================
// retire_unit : in-order retire of queued tags with fault flush/hold.  Rev 1.0
// Optional: RETIRE_CMPL_BYPASS_EN (same-cycle completion bypass to head).
// ============================================================================
module retire_unit
    import mips_pkg::*;
#(
    parameter int TAG_W        = MIPS_TAG_W,
    parameter int FLUSH_CYCLES = MIPS_FLUSH_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             oq_empty,
    input  logic [TAG_W-1:0] oq_data,
    output logic             oq_rd_en,
    output logic             oq_clear,
    input  logic             cmpl_valid,
    input  logic [TAG_W-1:0] cmpl_tag,
    input  logic             cmpl_exc,
    input  logic             commit_stall,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic             exc_valid,
    output logic [TAG_W-1:0] exc_tag,
    output logic             busy,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic [HOLD_CNT_W-1:0] c_HOLD_INIT = HOLD_CNT_W'(FLUSH_CYCLES);
    localparam logic [HOLD_CNT_W-1:0] c_HOLD_ONE  = HOLD_CNT_W'(1);

    retire_state_e           state_q, state_d;
    logic [HOLD_CNT_W-1:0]   hold_q,  hold_d;

    logic                    commit_valid_q;
    logic [TAG_W-1:0]        commit_tag_q;
    logic                    exc_valid_q;
    logic [TAG_W-1:0]        exc_tag_q;
    logic                    oq_clear_q;
    logic [CNT_W-1:0]        retire_cnt_q;

    logic w_run;
    logic w_head_done;
    logic w_head_exc;
    logic w_head_ready;
    logic w_pop;
    logic w_fault;

    assign w_run        = (state_q == RUN);
    assign w_head_ready = w_run && !oq_empty && w_head_done && !commit_stall;
    assign w_pop        = w_head_ready && !w_head_exc;
    assign w_fault      = w_head_ready &&  w_head_exc;

    tag_status_table #(
        .TAG_W (TAG_W)
    ) u_table (
        .clock       (clock),
        .nreset      (nreset),
        .set_en_i    (w_run && cmpl_valid),
        .set_tag_i   (cmpl_tag),
        .set_exc_i   (cmpl_exc),
        .clr_en_i    (w_pop),
        .clr_tag_i   (oq_data),
        .clr_all_i   (state_q == FLUSH),
        .head_tag_i  (oq_data),
        .head_done_o (w_head_done),
        .head_exc_o  (w_head_exc)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= RUN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            RUN: begin
                if (w_fault) state_d = FLUSH;
            end
            FLUSH: begin
                hold_d  = c_HOLD_INIT;
                state_d = HOLD;
            end
            HOLD: begin
                // Range-checked for <= 1 so a zero count can never stall here.
                if (hold_q <= c_HOLD_ONE) begin
                    hold_d  = '0;
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - c_HOLD_ONE;
                end
            end
            default: begin
                hold_d  = '0;
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            commit_valid_q <= 1'b0;
            commit_tag_q   <= '0;
            exc_valid_q    <= 1'b0;
            exc_tag_q      <= '0;
            oq_clear_q     <= 1'b0;
            retire_cnt_q   <= '0;
        end else begin
            commit_valid_q <= w_pop;
            exc_valid_q    <= w_fault;
            oq_clear_q     <= w_fault;
            if (w_pop) begin
                commit_tag_q <= oq_data;
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
            if (w_fault) exc_tag_q <= oq_data;
        end
    end

    assign oq_rd_en     = w_pop;
    assign oq_clear     = oq_clear_q;
    assign commit_valid = commit_valid_q;
    assign commit_tag   = commit_tag_q;
    assign exc_valid    = exc_valid_q;
    assign exc_tag      = exc_tag_q;
    assign busy         = !w_run;
    assign retire_cnt   = retire_cnt_q;

endmodule : retire_unit
`default_nettype wire

// File: tb/tb_retire_unit.sv
`default_nettype none
// ============================================================================
// tb_retire_unit : directed + random bench with a tag-queue/status model.  Rev 1.0
// ============================================================================
module tb_retire_unit;

    localparam int TW  = 5;
    localparam int FC  = 4;
`ifdef RETIRE_CMPL_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam int LAT = (BYP != 0) ? 1 : 2;

    logic          clock = 1'b0;
    logic          nreset = 1'b1;
    logic          oq_empty = 1'b1;
    logic [TW-1:0] oq_data = '0;
    logic          oq_rd_en;
    logic          oq_clear;
    logic          cmpl_valid = 1'b0;
    logic [TW-1:0] cmpl_tag = '0;
    logic          cmpl_exc = 1'b0;
    logic          commit_stall = 1'b0;
    logic          commit_valid;
    logic [TW-1:0] commit_tag;
    logic          exc_valid;
    logic [TW-1:0] exc_tag;
    logic          busy;
    logic [31:0]   retire_cnt;

    always #5 clock = ~clock;

    retire_unit #(.TAG_W(TW), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
        .clock        (clock),
        .nreset       (nreset),
        .oq_empty     (oq_empty),
        .oq_data      (oq_data),
        .oq_rd_en     (oq_rd_en),
        .oq_clear     (oq_clear),
        .cmpl_valid   (cmpl_valid),
        .cmpl_tag     (cmpl_tag),
        .cmpl_exc     (cmpl_exc),
        .commit_stall (commit_stall),
        .commit_valid (commit_valid),
        .commit_tag   (commit_tag),
        .exc_valid    (exc_valid),
        .exc_tag      (exc_tag),
        .busy         (busy),
        .retire_cnt   (retire_cnt)
    );

    int vectors = 0;
    int miscompares = 0;

    // Environment queue plus the architectural status the outputs must reflect.
    bit [TW-1:0] q[$];
    bit          m_done[32];
    bit          m_exc[32];
    int          busy_left;
    bit          e_cv, e_ev, e_clr;
    bit [TW-1:0] e_ct, e_et;
    bit [31:0]   e_cnt;
    bit          last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_done[i] = 1'b0;
            m_exc[i]  = 1'b0;
        end
        busy_left = 0;
        e_cv = 0; e_ev = 0; e_clr = 0; e_ct = '0; e_et = '0; e_cnt = '0;
        q.delete();
    endtask

    task automatic drive_q();
        oq_empty = (q.size() == 0);
        oq_data  = (q.size() != 0) ? q[0] : '0;
    endtask

    // One clock: check at negedge, advance the model at posedge, then release strobes.
    task automatic step();
        bit run, hd, he, ready, pop, flt;
        bit [TW-1:0] head;
        drive_q();
        @(negedge clock);
        run  = (busy_left == 0);
        head = oq_data;
        hd   = m_done[head];
        he   = m_exc[head];
        if (BYP != 0 && run && cmpl_valid && cmpl_tag == head) begin
            hd = 1'b1;
            he = cmpl_exc;
        end
        ready = run && !oq_empty && hd && !commit_stall;
        pop   = ready && !he;
        flt   = ready && he;
        chk("oq_rd_en",     oq_rd_en,     pop);
        chk("commit_valid", commit_valid, e_cv);
        chk("commit_tag",   commit_tag,   e_ct);
        chk("exc_valid",    exc_valid,    e_ev);
        chk("exc_tag",      exc_tag,      e_et);
        chk("oq_clear",     oq_clear,     e_clr);
        chk("busy",         busy,         busy_left != 0);
        chk("retire_cnt",   retire_cnt,   e_cnt);
        last_rd = oq_rd_en;
        @(posedge clock);
        if (run && cmpl_valid) begin
            m_done[cmpl_tag] = 1'b1;
            m_exc[cmpl_tag]  = cmpl_exc;
        end
        if (pop) begin
            m_done[head] = 1'b0;
            m_exc[head]  = 1'b0;
            void'(q.pop_front());
            e_ct  = head;
            e_cnt = e_cnt + 1;
        end
        e_cv  = pop;
        e_ev  = flt;
        e_clr = flt;
        if (flt) e_et = head;
        if (busy_left == FC + 1) begin
            for (int i = 0; i < 32; i++) begin
                m_done[i] = 1'b0;
                m_exc[i]  = 1'b0;
            end
            q.delete();
        end
        if (busy_left > 0) busy_left--;
        if (flt) busy_left = FC + 1;
        #1;
        cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_exc = 1'b0; commit_stall = 1'b0;
        drive_q();
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        model_reset();
        cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_exc = 1'b0; commit_stall = 1'b0;
        drive_q();
        #2;
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_tag",   commit_tag,   0);
        chk("rst_exc_valid",    exc_valid,    0);
        chk("rst_oq_clear",     oq_clear,     0);
        chk("rst_busy",         busy,         0);
        chk("rst_retire_cnt",   retire_cnt,   0);
        chk("rst_oq_rd_en",     oq_rd_en,     0);
        @(posedge clock);
        #1 nreset = 1'b1;
    endtask

    task automatic wait_commit(input string name, input int exp_lat, input logic [TW-1:0] exp_tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!commit_valid && n < 20);
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_tag"}, commit_tag, exp_tag);
    endtask

    task automatic wait_exc(input string name, input int exp_lat, input logic [TW-1:0] exp_tag);
        int n = 0;
        do begin
            step();
            n++;
        end while (!exc_valid && n < 20);
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_exc_tag"}, exc_tag, exp_tag);
        chk({name, "_oq_clear"}, oq_clear, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    function automatic bit in_q(input bit [TW-1:0] t);
        foreach (q[i]) if (q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        int  n;
        bit  seen;
        bit [TW-1:0] t;
        #2;
        do_reset();

        // In-order retire: 7 completes first but must wait behind 3.
        q.push_back(5'd3); q.push_back(5'd7);
        step();
        chk("t1_idle_rd", last_rd, 0);
        cmpl_valid = 1; cmpl_tag = 5'd7; step();
        chk("t1_early_a", commit_valid, 0);
        step();
        chk("t1_early_b", commit_valid, 0);
        cmpl_valid = 1; cmpl_tag = 5'd3;
        wait_commit("t1_first", LAT, 5'd3);
        step();
        chk("t1_second_valid", commit_valid, 1);
        chk("t1_second_tag",   commit_tag,   7);
        chk("t1_count",        retire_cnt,   2);

        // Stall: head done but held off for three cycles.
        q.push_back(5'd5);
        cmpl_valid = 1; cmpl_tag = 5'd5; commit_stall = 1; step();
        chk("t2_stall_a", last_rd, 0);
        commit_stall = 1; step();
        chk("t2_stall_b", last_rd, 0);
        commit_stall = 1; step();
        chk("t2_stall_c", last_rd, 0);
        step();
        chk("t2_release_rd", last_rd, 1);
        chk("t2_commit",     commit_valid, 1);
        chk("t2_tag",        commit_tag, 5);

        // Exception at head: flush, 1+FC busy cycles, younger 9 never retires.
        q.push_back(5'd2); q.push_back(5'd9); q.push_back(5'd4);
        cmpl_valid = 1; cmpl_tag = 5'd9; step();
        cmpl_valid = 1; cmpl_tag = 5'd2; cmpl_exc = 1;
        wait_exc("t3", LAT, 5'd2);
        n = 1; seen = 0;
        do begin
            step();
            if (commit_valid) seen = 1;
            if (busy) n++;
        end while (busy && n < 20);
        chk("t3_busy_cycles", n, FC + 1);
        chk("t3_no_commit", seen, 0);

        // Completion during HOLD is dropped.
        q.push_back(5'd1);
        cmpl_valid = 1; cmpl_tag = 5'd1; cmpl_exc = 1;
        wait_exc("t4", LAT, 5'd1);
        step();
        cmpl_valid = 1; cmpl_tag = 5'd6; step();
        wait_idle();
        q.push_back(5'd6);
        step();
        chk("t4_stale_a", commit_valid, 0);
        step();
        chk("t4_stale_b", commit_valid, 0);
        cmpl_valid = 1; cmpl_tag = 5'd6;
        wait_commit("t4_fresh", LAT, 5'd6);

        // Reset while holding, then a normal retire.
        q.push_back(5'd8);
        cmpl_valid = 1; cmpl_tag = 5'd8; cmpl_exc = 1;
        wait_exc("t5", LAT, 5'd8);
        step();
        chk("t5_in_hold", busy, 1);
        do_reset();
        q.push_back(5'd10);
        step();
        cmpl_valid = 1; cmpl_tag = 5'd10;
        wait_commit("t5_after_rst", LAT, 5'd10);
        chk("t5_count", retire_cnt, 1);

        // Random traffic against the model.
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) do_reset();
            if (q.size() < 6 && $urandom_range(0, 2) == 0) begin
                t = TW'($urandom);
                while (in_q(t)) t = t + 1'b1;
                q.push_back(t);
            end
            if ($urandom_range(0, 3) != 0) begin
                cmpl_valid = 1;
                if (q.size() != 0 && $urandom_range(0, 3) != 0)
                    cmpl_tag = q[$urandom_range(0, q.size() - 1)];
                else
                    cmpl_tag = TW'($urandom);
                cmpl_exc = ($urandom_range(0, 15) == 0);
            end
            commit_stall = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_retire_unit
`default_nettype wire
